delta_mod_scheduler: RTL and testbench
======================================

// Module: delta_mod_scheduler
// PURPOSE
//  Time-multiplexes one 4-bit delta-modulation compare path across NCH input channels.
//  Accepts one sample vector per handshake and scans the channels one per cycle.
//  For each channel it compares the new sample against that channel's stored prev value.
//  Resulting spike events are queued in a small FIFO toward the output pins.
//  Also provides per-channel prev force-load and a prev readback port for bring-up.
// PARAMETERS
//  NCH    4  number of channels (2..8); channel index width CW = $clog2(NCH)
//  DW     4  sample/prev/threshold width in bits
//  DEPTH  4  event FIFO depth (power of 2, >=2)
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  rst_n         in   1       asynchronous active-low reset
//  ena           in   1       design enable; low freezes all state, blocks all handshakes
//  sample_valid  in   1       sample vector offered
//  sample_ready  out  1       IDLE & ena & ~force_valid (combinational)
//  sample_data   in   NCH*DW  channel k at [k*DW +: DW]
//  threshold     in   DW      spike threshold, sampled with sample vector
//  off_spike     in   1       sampled with vector: 1 = suppress events, still update prev
//  force_valid   in   1       force-load request
//  force_ready   out  1       IDLE & ena (combinational)
//  force_ch      in   CW      channel to force
//  force_value   in   DW      value written to prev[force_ch]
//  event_valid   out  1       FIFO head valid (0 while ena low)
//  event_ready   in   1       consumer pop
//  event_ch      out  CW      channel of head event
//  event_spike   out  2       01 = up, 10 = down (00/11 never emitted)
//  busy          out  1       state != IDLE
//  prev_sel      in   CW      readback select
//  prev_rd       out  DW      prev[prev_sel], combinational
// BEHAVIOUR
//  Reset: FSM=IDLE, all prev=0, FIFO empty; event_valid=0, busy=0.
//  Reset: event_ch=0, event_spike=00, latched vector/threshold/off_spike=0.
//  FSM IDLE:
//   - force_valid&ena: prev[force_ch]<=force_value; force wins over sample that cycle.
//   - Else sample_valid&sample_ready: latch vector, threshold, off_spike; idx<=0; go SCAN.
//  FSM SCAN: one channel per cycle at idx; d=data[idx], p=prev[idx].
//   - Unsigned compare, DW+1-bit difference.
//   - d>p and d-p>=threshold: spike=01. p>d and p-d>=threshold: spike=10.
//   - Otherwise no spike. d==p never spikes, even with threshold=0.
//   - On spike: prev[idx]<=d; push {idx,spike} unless off_spike.
//   - No spike: prev unchanged, no push.
//   - Stall when spike & ~off_spike & FIFO full: no prev update, idx holds, retry next cycle.
//   - idx==NCH-1 and not stalled: go IDLE next cycle.
//  Latency: accept at T; channel k evaluated at T+1+k plus stall cycles.
//  Latency: event visible on event_valid at T+2+k. sample_ready high again at T+1+NCH min.
//  FIFO:
//   - Pop when event_valid&event_ready.
//   - Push uses count<DEPTH at start of cycle; no full-bypass.
//   - Simultaneous push+pop when not full/empty: count unchanged, order preserved.
//   - Pop from empty impossible (event_valid=0).
//  ena low: FSM, idx, FIFO, prev frozen; sample_ready=force_ready=event_valid=0.
//  ena high again: resumes exactly where it stopped.
//  Async reset mid-SCAN: scan aborted, queued events discarded, all prev cleared.
// TESTING
//  1 reset; force ch2=9; prev_sel=2 -> prev_rd=9, other channels 0, busy=0.
//  2 thr=3, data ch0..3={5,2,0,15}, prev=0, ready=1.
//    -> events (0,01),(3,01) in order; prev={5,0,0,15}; busy 4 cycles.
//  3 prev=8, thr=0, data=8 -> no event; data=7 -> (ch,10), prev=7.
//  4 event_ready=0, DEPTH=4, NCH=4, thr=1, data all 15 then all 0.
//    -> 4 events queued; second scan stalls at ch0, busy stays 1.
//    -> raise ready: 8 events total, order ch0..3 up then ch0..3 down.
//  5 off_spike=1, data=15 -> no events, all prev=15.
//    force_valid and sample_valid same IDLE cycle -> force applied, sample_ready=0.
//  6 ena low for 5 cycles mid-scan -> no state change, event_valid=0.
//    rst_n low mid-scan -> event_valid=0, prev all 0 immediately.

Source files
------------

// File: rtl/delta_mod_scheduler.sv
// Delta-modulation spike scheduler: one shared compare path scanned across NCH
// channels, with per-channel prev state, force-load/readback and an event FIFO.
module delta_mod_scheduler #(
  parameter int NCH   = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [NCH*DW-1:0] sample_data,
  input  logic [DW-1:0]     threshold,
  input  logic              off_spike,
  input  logic              force_valid,
  output logic              force_ready,
  input  logic [CW-1:0]     force_ch,
  input  logic [DW-1:0]     force_value,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [CW-1:0]     event_ch,
  output logic [1:0]        event_spike,
  output logic              busy,
  input  logic [CW-1:0]     prev_sel,
  output logic [DW-1:0]     prev_rd
);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [CW:0]   NCH_W    = (CW+1)'(NCH);
  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   idx_r, idx_nxt_s;
  logic [DW-1:0]   sample_r [NCH];
  logic [DW-1:0]   thr_r;
  logic            off_r;
  logic [DW-1:0]   prev_r [NCH];
  logic [CW-1:0]   fifo_ch_r [DEPTH];
  logic [1:0]      fifo_spk_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]     count_r;

  logic [DW-1:0]   cur_d_s, cur_p_s;
  logic [DW:0]     up_diff_s, dn_diff_s;
  logic [1:0]      spike_s;
  logic            fifo_full_s, push_req_s, stall_s;
  logic            accept_s, force_wr_s, prev_wr_s, push_s, pop_s;

  // Compare the current channel's sample against its stored prev value
  always_comb begin
    cur_d_s    = sample_r[idx_r];
    cur_p_s    = prev_r[idx_r];
    up_diff_s  = {1'b0, cur_d_s} - {1'b0, cur_p_s};
    dn_diff_s  = {1'b0, cur_p_s} - {1'b0, cur_d_s};
    if ((cur_d_s > cur_p_s) && (up_diff_s >= {1'b0, thr_r})) begin
      spike_s = 2'b01;
    end else if ((cur_p_s > cur_d_s) && (dn_diff_s >= {1'b0, thr_r})) begin
      spike_s = 2'b10;
    end else begin
      spike_s = 2'b00;
    end
    fifo_full_s = (count_r == DEPTH_W);
    push_req_s  = (spike_s != 2'b00) && !off_r;
    stall_s     = push_req_s && fifo_full_s;
  end

  // Next-state and per-cycle control strobes; nothing moves while ena is low
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    accept_s    = 1'b0;
    force_wr_s  = 1'b0;
    prev_wr_s   = 1'b0;
    push_s      = 1'b0;
    if (ena) begin
      case (state_r)
        IDLE: begin
          if (force_valid) begin
            force_wr_s = ({1'b0, force_ch} < NCH_W);
          end else if (sample_valid) begin
            accept_s    = 1'b1;
            idx_nxt_s   = '0;
            state_nxt_s = SCAN;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        SCAN: begin
          if (stall_s) begin
            state_nxt_s = SCAN;
          end else begin
            prev_wr_s = (spike_s != 2'b00);
            push_s    = push_req_s;
            if (idx_r == LAST_IDX) begin
              state_nxt_s = IDLE;
            end else begin
              idx_nxt_s = idx_r + 1'b1;
            end
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign sample_ready = ena && (state_r == IDLE) && !force_valid;
  assign force_ready  = ena && (state_r == IDLE);
  assign busy         = (state_r != IDLE);
  assign event_valid  = ena && (count_r != '0);
  assign pop_s        = event_valid && event_ready;
  assign event_ch     = fifo_ch_r[rd_ptr_r];
  assign event_spike  = fifo_spk_r[rd_ptr_r];

  // Readback of one channel's prev value
  always_comb begin
    if ({1'b0, prev_sel} < NCH_W) begin
      prev_rd = prev_r[prev_sel];
    end else begin
      prev_rd = '0;
    end
  end

  // FSM, scan index and latched sample vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= '0;
      thr_r   <= '0;
      off_r   <= 1'b0;
      for (int k = 0; k < NCH; k++) sample_r[k] <= '0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      if (accept_s) begin
        thr_r <= threshold;
        off_r <= off_spike;
        for (int k = 0; k < NCH; k++) sample_r[k] <= sample_data[k*DW +: DW];
      end
    end
  end

  // Per-channel prev storage: force-load has priority over scan update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) prev_r[k] <= '0;
    end else if (force_wr_s) begin
      prev_r[force_ch] <= force_value;
    end else if (prev_wr_s) begin
      prev_r[idx_r] <= cur_d_s;
    end
  end

  // Event FIFO; push is gated on occupancy at the start of the cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        fifo_ch_r[k]  <= '0;
        fifo_spk_r[k] <= 2'b00;
      end
    end else begin
      if (push_s) begin
        fifo_ch_r[wr_ptr_r]  <= idx_r;
        fifo_spk_r[wr_ptr_r] <= spike_s;
        wr_ptr_r             <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_delta_mod_scheduler.sv
// Scoreboard bench for delta_mod_scheduler: expected events are queued when a
// sample vector is sent and compared as the DUT hands them out.
module tb_delta_mod_scheduler;
  logic        clk = 1'b0;
  logic        rst_n, ena, sample_valid, sample_ready;
  logic [15:0] sample_data;
  logic [3:0]  threshold;
  logic        off_spike, force_valid, force_ready;
  logic [1:0]  force_ch;
  logic [3:0]  force_value;
  logic        event_valid, event_ready;
  logic [1:0]  event_ch, event_spike;
  logic        busy;
  logic [1:0]  prev_sel;
  logic [3:0]  prev_rd;

  int          vectors = 0;
  int          miscompares = 0;
  int          popped = 0;
  logic [3:0]  sb[$];
  logic [3:0]  mon_exp;
  int          exp_prev[4];

  delta_mod_scheduler #(.NCH(4), .DW(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .threshold(threshold), .off_spike(off_spike),
    .force_valid(force_valid), .force_ready(force_ready),
    .force_ch(force_ch), .force_value(force_value),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_ch(event_ch), .event_spike(event_spike),
    .busy(busy), .prev_sel(prev_sel), .prev_rd(prev_rd)
  );

  always #5 clk = ~clk;

  // Scoreboard: every handed-out event must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n && event_valid && event_ready) begin
      vectors++;
      popped++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL event_unexpected: got ch=%0d spike=%b, required no event", event_ch, event_spike);
      end else begin
        mon_exp = sb.pop_front();
        if ({event_ch, event_spike} !== mon_exp) begin
          miscompares++;
          $display("FAIL event_order: got ch=%0d spike=%b, required ch=%0d spike=%b",
                   event_ch, event_spike, mon_exp[3:2], mon_exp[1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_force(input int ch, input int val);
    force_valid = 1'b1;
    force_ch    = ch[1:0];
    force_value = val[3:0];
    tick();
    force_valid = 1'b0;
    exp_prev[ch] = val;
  endtask

  task automatic send_vec(input logic [15:0] data, input int thr, input bit off);
    int n = 0;
    int d, p;
    logic [1:0] sp;
    while (!sample_ready && n < 60) begin
      tick();
      n++;
    end
    vectors++;
    if (sample_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_ready_timeout: sample_ready=%b, required 1", sample_ready);
    end
    for (int k = 0; k < 4; k++) begin
      d = int'(data[k*4 +: 4]);
      p = exp_prev[k];
      if (d > p && d - p >= thr) sp = 2'b01;
      else if (p > d && p - d >= thr) sp = 2'b10;
      else sp = 2'b00;
      if (sp != 2'b00) begin
        exp_prev[k] = d;
        if (!off) sb.push_back({k[1:0], sp});
      end
    end
    sample_data  = data;
    threshold    = thr[3:0];
    off_spike    = off;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: busy=%b pending=%0d, required busy=0 pending=0", busy, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; sample_valid = 1'b0; sample_data = '0; threshold = '0;
    off_spike = 1'b0; force_valid = 1'b0; force_ch = '0; force_value = '0;
    event_ready = 1'b1; prev_sel = '0;
    for (int k = 0; k < 4; k++) exp_prev[k] = 0;
    #1;
    vectors++;
    if (event_valid !== 1'b0 || busy !== 1'b0 || event_ch !== 2'd0 || event_spike !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_outputs: ev=%b busy=%b ch=%0d spike=%b, required 0 0 0 00",
               event_valid, busy, event_ch, event_spike);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_force(2, 9);
    for (int k = 0; k < 4; k++) begin
      prev_sel = k[1:0];
      #1;
      vectors++;
      if (prev_rd !== ((k == 2) ? 4'd9 : 4'd0)) begin
        miscompares++;
        $display("FAIL reset_force_prev ch%0d: got %0d, required %0d", k, prev_rd, (k == 2) ? 9 : 0);
      end
    end
    vectors++;
    if (busy !== 1'b0 || sample_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b ready=%b, required 0 1", busy, sample_ready);
    end
  endtask

  task automatic test_basic_scan();
    int n = 0;
    int base = popped;
    do_force(2, 0);
    send_vec({4'd15, 4'd0, 4'd2, 4'd5}, 3, 1'b0);
    while (busy && n < 20) begin
      vectors++;
      if (sample_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL scan_ready_low: sample_ready=%b, required 0", sample_ready);
      end
      n++;
      tick();
    end
    vectors++;
    if (n != 4 || sample_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL scan_busy_cycles: got %0d ready=%b, required 4 ready=1", n, sample_ready);
    end
    wait_drain();
    vectors++;
    if (popped - base != 2) begin
      miscompares++;
      $display("FAIL scan_event_count: got %0d, required 2", popped - base);
    end
    for (int k = 0; k < 4; k++) begin
      prev_sel = k[1:0];
      #1;
      vectors++;
      if (prev_rd !== ((k == 0) ? 4'd5 : (k == 3) ? 4'd15 : 4'd0)) begin
        miscompares++;
        $display("FAIL scan_prev ch%0d: got %0d, required %0d", k, prev_rd, (k == 0) ? 5 : (k == 3) ? 15 : 0);
      end
    end
  endtask

  task automatic test_down_and_equal();
    int base;
    do_force(1, 8);
    base = popped;
    send_vec({4'd15, 4'd0, 4'd8, 4'd5}, 0, 1'b0);
    wait_drain();
    vectors++;
    if (popped != base) begin
      miscompares++;
      $display("FAIL equal_no_event: got %0d events, required 0", popped - base);
    end
    send_vec({4'd15, 4'd0, 4'd7, 4'd5}, 0, 1'b0);
    wait_drain();
    prev_sel = 2'd1;
    #1;
    vectors++;
    if (popped - base != 1 || prev_rd !== 4'd7) begin
      miscompares++;
      $display("FAIL down_event: events=%0d prev=%0d, required 1 and 7", popped - base, prev_rd);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    do_force(0, 0); do_force(1, 0); do_force(3, 0);
    event_ready = 1'b0;
    base = popped;
    send_vec(16'hFFFF, 1, 1'b0);
    send_vec(16'h0000, 1, 1'b0);
    repeat (6) tick();
    prev_sel = 2'd0;
    #1;
    vectors++;
    if (busy !== 1'b1 || event_valid !== 1'b1 || prev_rd !== 4'd15) begin
      miscompares++;
      $display("FAIL stall_hold: busy=%b ev=%b prev0=%0d, required 1 1 15", busy, event_valid, prev_rd);
    end
    vectors++;
    if (event_ch !== 2'd0 || event_spike !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_head: ch=%0d spike=%b, required 0 01", event_ch, event_spike);
    end
    event_ready = 1'b1;
    wait_drain();
    vectors++;
    if (popped - base != 8) begin
      miscompares++;
      $display("FAIL stall_event_count: got %0d, required 8", popped - base);
    end
    for (int k = 0; k < 4; k++) begin
      prev_sel = k[1:0];
      #1;
      vectors++;
      if (prev_rd !== 4'd0) begin
        miscompares++;
        $display("FAIL stall_prev ch%0d: got %0d, required 0", k, prev_rd);
      end
    end
  endtask

  task automatic test_off_spike_and_force();
    int base = popped;
    send_vec(16'hFFFF, 0, 1'b1);
    wait_drain();
    vectors++;
    if (popped != base) begin
      miscompares++;
      $display("FAIL off_spike_events: got %0d, required 0", popped - base);
    end
    for (int k = 0; k < 4; k++) begin
      prev_sel = k[1:0];
      #1;
      vectors++;
      if (prev_rd !== 4'd15) begin
        miscompares++;
        $display("FAIL off_spike_prev ch%0d: got %0d, required 15", k, prev_rd);
      end
    end
    force_valid = 1'b1; force_ch = 2'd0; force_value = 4'd3;
    sample_valid = 1'b1; sample_data = 16'h0000; threshold = 4'd0; off_spike = 1'b0;
    #1;
    vectors++;
    if (sample_ready !== 1'b0 || force_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL force_priority_ready: sready=%b fready=%b, required 0 1", sample_ready, force_ready);
    end
    tick();
    force_valid = 1'b0; sample_valid = 1'b0;
    prev_sel = 2'd0;
    #1;
    vectors++;
    if (busy !== 1'b0 || prev_rd !== 4'd3) begin
      miscompares++;
      $display("FAIL force_priority: busy=%b prev0=%0d, required 0 3", busy, prev_rd);
    end
    exp_prev[0] = 3;
    do_force(0, 15);
  endtask

  task automatic test_ena_and_async_reset();
    int base = popped;
    send_vec(16'h0000, 1, 1'b0);
    tick();
    ena = 1'b0;
    prev_sel = 2'd1;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (event_valid !== 1'b0 || sample_ready !== 1'b0 || force_ready !== 1'b0 ||
          busy !== 1'b1 || prev_rd !== 4'd15) begin
        miscompares++;
        $display("FAIL ena_freeze cyc%0d: ev=%b sr=%b fr=%b busy=%b prev1=%0d, required 0 0 0 1 15",
                 c, event_valid, sample_ready, force_ready, busy, prev_rd);
      end
      tick();
    end
    ena = 1'b1;
    wait_drain();
    vectors++;
    if (popped - base != 4) begin
      miscompares++;
      $display("FAIL ena_resume_events: got %0d, required 4", popped - base);
    end
    event_ready = 1'b0;
    send_vec(16'hFFFF, 1, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (event_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: ev=%b busy=%b, required 0 0", event_valid, busy);
    end
    for (int k = 0; k < 4; k++) begin
      prev_sel = k[1:0];
      #1;
      vectors++;
      if (prev_rd !== 4'd0) begin
        miscompares++;
        $display("FAIL async_reset_prev ch%0d: got %0d, required 0", k, prev_rd);
      end
    end
    sb.delete();
    for (int k = 0; k < 4; k++) exp_prev[k] = 0;
    tick();
    rst_n = 1'b1;
    event_ready = 1'b1;
    tick();
    base = popped;
    send_vec({4'd0, 4'd0, 4'd0, 4'd6}, 2, 1'b0);
    wait_drain();
    vectors++;
    if (popped - base != 1) begin
      miscompares++;
      $display("FAIL post_reset_scan: got %0d events, required 1", popped - base);
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_down_and_equal();
    test_back_to_back();
    test_off_spike_and_force();
    test_ena_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
